// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random number generator: FSM encoding,
// feedback-structure selectors and a lookup of maximal-length tap masks.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } lfsr_state_e;

    localparam int MODE_GALOIS    = 0;
    localparam int MODE_FIBONACCI = 1;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;

    // Right-shift Galois masks giving a 2^n-1 period; returns 0 outside 4..32.
    function automatic logic [31:0] max_len_taps(input int width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_0009;
            5:       taps = 32'h0000_0012;
            6:       taps = 32'h0000_0021;
            7:       taps = 32'h0000_0041;
            8:       taps = 32'h0000_008E;
            9:       taps = 32'h0000_0108;
            10:      taps = 32'h0000_0204;
            11:      taps = 32'h0000_0402;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_4001;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_0004;
            18:      taps = 32'h0002_0013;
            19:      taps = 32'h0004_0013;
            20:      taps = 32'h0008_0004;
            21:      taps = 32'h0010_0002;
            22:      taps = 32'h0020_0001;
            23:      taps = 32'h0040_0010;
            24:      taps = 32'h0080_000D;
            25:      taps = 32'h0100_0004;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0800_0004;
            29:      taps = 32'h1000_0002;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4000_0004;
            32:      taps = 32'h8000_0057;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Pure combinational single-step function of the LFSR: Galois (right shift)
// or Fibonacci (left shift) depending on MODE.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter int               MODE  = MODE_GALOIS
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    always_comb begin
        if (MODE == MODE_FIBONACCI) begin
            state_out = {state_in[WIDTH-2:0], ^(state_in & TAPS)};
        end else if (state_in[0]) begin
            state_out = (state_in >> 1) ^ TAPS;
        end else begin
            state_out = state_in >> 1;
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random word generator: free-runs while idle, and on req advances STEPS
// times before publishing a decorrelated word on rnd_out with a valid pulse.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int               STEPS = 2,
    parameter int               MODE  = MODE_GALOIS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rnd_out,
    output logic             lock_err
);

    localparam int               CNT_W    = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lfsr_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] step_w;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_step (
        .state_in  (state_q),
        .state_out (step_w)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        lock_d  = 1'b0;
        if (seed_load) begin
            // A zero seed would lock the register, so it maps to SEED.
            state_d = (seed_in == '0) ? SEED : seed_in;
            fsm_d   = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    if (req) begin
                        fsm_d  = ST_SHIFT;
                        cnt_d  = CNT_LOAD;
                        busy_d = 1'b1;
                    end else if (en) begin
                        state_d = step_w;
                    end
                end
                ST_SHIFT: begin
                    state_d = step_w;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) fsm_d = ST_DONE;
                end
                ST_DONE: begin
                    rnd_d   = state_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = ST_IDLE;
                end
                default: fsm_d = ST_IDLE;
            endcase
            // Zero-state recovery replaces whatever step was due this cycle.
            if (state_q == '0) begin
                state_d = SEED;
                lock_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= SEED;
            rnd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign rnd_out  = rnd_q;
    assign lock_err = lock_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng with default parameters: vector table,
// randomized transactions against a reference model, and corner sequences.
module tb_lfsr_rng;

    localparam int          W     = 16;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          STEPS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         seed_load;
    logic [W-1:0] seed_in;
    logic         req;
    logic         busy;
    logic         valid;
    logic [W-1:0] rnd_out;
    logic         lock_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] seed;
        int           en_n;
        bit           do_req;
        logic [W-1:0] exp_state;
        logic [W-1:0] exp_rnd;
    } vec_t;

    vec_t vecs [8];
    bit   seen [0:65535];

    always #5 clk = ~clk;

    lfsr_rng #(
        .WIDTH (W),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .STEPS (STEPS),
        .MODE  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .busy      (busy),
        .valid     (valid),
        .rnd_out   (rnd_out),
        .lock_err  (lock_err)
    );

    // Reference: polynomial step written as plain arithmetic on the value.
    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        if ((s % 2) == 1) return (s / 2) ^ TAPS;
        return s / 2;
    endfunction

    function automatic logic [W-1:0] model_adv(input logic [W-1:0] s, input int n);
        logic [W-1:0] r = s;
        for (int k = 0; k < n; k++) r = model_step(r);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [W-1:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        cyc();
        seed_load = 1'b0;
        seed_in   = '0;
    endtask

    task automatic do_req(input logic [W-1:0] exp, input bit hold_req, input string tag);
        int busy_n  = 0;
        int valid_n = 0;
        int valid_at = 0;
        int lock_n  = 0;
        req = 1'b1;
        cyc();
        req = hold_req;
        for (int i = 1; i <= STEPS + 6; i++) begin
            if (busy) busy_n++;
            if (valid) begin
                valid_n++;
                valid_at = i;
                check({tag, "_rnd"}, 32'(rnd_out), 32'(exp));
            end
            if (lock_err) lock_n++;
            if (i >= STEPS + 1) req = 1'b0;
            cyc();
        end
        check({tag, "_valid_count"}, 32'(valid_n), 32'd1);
        check({tag, "_latency"}, 32'(valid_at), 32'(STEPS + 2));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(STEPS + 1));
        check({tag, "_no_lock"}, 32'(lock_n), 32'd0);
        check({tag, "_rnd_hold"}, 32'(rnd_out), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] m;
        int           mism;
        int           early;
        int           locks;
        int           vcount;

        rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0;
        #2;
        check("reset_state", 32'(dut.state_q), 32'(SEED));
        check("reset_rnd", 32'(rnd_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_lock", 32'(lock_err), 32'd0);
        #10;
        rst = 1'b0;
        cyc();

        // Vector table: seed, free-run steps, optional request, expectations.
        vecs[0] = '{16'h0000, 0, 1'b0, 16'hACE1, 16'h0000};
        vecs[1] = '{16'h0000, 1, 1'b0, 16'hE270, 16'h0000};
        vecs[2] = '{16'h0000, 0, 1'b1, 16'h7138, 16'h7138};
        vecs[3] = '{16'h0001, 0, 1'b1, 16'h5A00, 16'h5A00};
        vecs[4] = '{16'h8000, 3, 1'b0, 16'h1000, 16'h0000};
        vecs[5] = '{16'hACE1, 2, 1'b0, 16'h7138, 16'h0000};
        vecs[6] = '{16'h0001, 1, 1'b0, 16'hB400, 16'h0000};
        vecs[7] = '{16'hFFFF, 0, 1'b1, 16'hD1FF, 16'hD1FF};
        for (int v = 0; v < 8; v++) begin
            load_seed(vecs[v].seed);
            en = 1'b1;
            repeat (vecs[v].en_n) cyc();
            en = 1'b0;
            if (vecs[v].do_req) do_req(vecs[v].exp_rnd, 1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_state", v), 32'(dut.state_q), 32'(vecs[v].exp_state));
        end

        // Randomized transactions against the model.
        for (int t = 0; t < 25; t++) begin
            logic [W-1:0] s;
            int           n;
            s = W'($urandom_range(0, 16'hFFFF));
            load_seed(s);
            m = (s == '0) ? SEED : s;
            n = $urandom_range(0, 12);
            for (int k = 0; k < n; k++) begin
                en = 1'($urandom_range(0, 1));
                cyc();
                if (en) m = model_step(m);
            end
            en = 1'b0;
            check($sformatf("rand%0d_state", t), 32'(dut.state_q), 32'(m));
            if ($urandom_range(0, 1) == 1) begin
                m = model_adv(m, STEPS);
                do_req(m, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
                check($sformatf("rand%0d_post_state", t), 32'(dut.state_q), 32'(m));
            end
        end

        // Request with en held high: SHIFT must not take extra steps.
        load_seed(SEED);
        en = 1'b1;
        do_req(16'h7138, 1'b0, "req_en_high");
        en = 1'b0;

        // Full-period free run from the default seed.
        load_seed(16'h0000);
        check("period_start", 32'(dut.state_q), 32'(SEED));
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        seen[SEED] = 1'b1;
        m = SEED; mism = 0; early = 0; locks = 0;
        en = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            cyc();
            m = model_step(m);
            if (dut.state_q !== m) mism++;
            if (lock_err) locks++;
            if (i < 65535) begin
                if (seen[dut.state_q]) early++;
                seen[dut.state_q] = 1'b1;
            end
        end
        en = 1'b0;
        check("period_trace_mismatches", 32'(mism), 32'd0);
        check("period_early_repeats", 32'(early), 32'd0);
        check("period_lock_pulses", 32'(locks), 32'd0);
        check("period_end_state", 32'(dut.state_q), 32'(SEED));

        // Abort a request with seed_load while SHIFT is under way.
        load_seed(SEED);
        do_req(16'h7138, 1'b0, "pre_abort");
        req = 1'b1;
        cyc();
        req = 1'b1;
        cyc();
        req = 1'b0;
        seed_load = 1'b1;
        seed_in = 16'h0001;
        cyc();
        seed_load = 1'b0;
        seed_in = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'h0001);
        vcount = 0;
        for (int i = 0; i < STEPS + 4; i++) begin
            if (valid) vcount++;
            if (busy) vcount++;
            cyc();
        end
        check("abort_no_valid", 32'(vcount), 32'd0);
        check("abort_rnd_kept", 32'(rnd_out), 32'h7138);

        // Zero-state recovery via a deposited all-zero state.
        force dut.state_q = '0;
        #1;
        release dut.state_q;
        cyc();
        check("lock_state", 32'(dut.state_q), 32'(SEED));
        check("lock_pulse", 32'(lock_err), 32'd1);
        cyc();
        check("lock_pulse_single", 32'(lock_err), 32'd0);
        check("lock_state_hold", 32'(dut.state_q), 32'(SEED));

        // Asynchronous reset in the middle of SHIFT.
        req = 1'b1;
        cyc();
        req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rnd", 32'(rnd_out), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(SEED));
        #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < STEPS + 6; i++) begin
            cyc();
            if (valid) vcount++;
            if (busy) vcount++;
        end
        check("arst_no_valid", 32'(vcount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
